// File: rtl/cska_wide_add_sched.sv
// rtl/cska_wide_add_sched.sv - round-robin scheduler running wide adds chunk-serially on one shared adder slice
// Build option CSKA_SCHED_EARLY_TERM_EN: finish as soon as no carry and no nonzero upper chunks remain.
module cska_wide_add_sched #(
  parameter int CHUNK_W    = 16,
  parameter int NUM_CHUNKS = 4,
  parameter int NUM_REQ    = 2,
  localparam int W   = CHUNK_W * NUM_CHUNKS,
  localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CIW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  output logic [CHUNK_W-1:0]   add_a,
  output logic [CHUNK_W-1:0]   add_b,
  output logic                 add_cin,
  input  logic [CHUNK_W:0]     add_sum,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [W:0]           res_sum,
  output logic [IW-1:0]        res_id,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      rr_ptr, id_q;
  logic [IW-1:0]      grant_idx, lo_idx, hi_idx;
  logic               lo_found, hi_found, grant_found;
  logic [CIW-1:0]     chunk_idx;
  logic               carry;
  logic [W-1:0]       op_a, op_b, sel_a, sel_b;
  logic [CHUNK_W-1:0] cur_a, cur_b;
  logic [W:0]         res_q;
  logic               chunk_last, early_done;

  // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
  always_comb begin
    lo_found = 1'b0;
    lo_idx   = '0;
    hi_found = 1'b0;
    hi_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = IW'(i);
      end
      if (req_valid[i] && (IW'(i) >= rr_ptr)) begin
        hi_found = 1'b1;
        hi_idx   = IW'(i);
      end
    end
    grant_found = lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IW'(i)) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  always_comb begin
    cur_a = '0;
    cur_b = '0;
    for (int c = 0; c < NUM_CHUNKS; c++) begin
      if (chunk_idx == CIW'(c)) begin
        cur_a = op_a[c*CHUNK_W +: CHUNK_W];
        cur_b = op_b[c*CHUNK_W +: CHUNK_W];
      end
    end
  end

  assign chunk_last = (chunk_idx == CIW'(NUM_CHUNKS - 1));

`ifdef CSKA_SCHED_EARLY_TERM_EN
  // Looks past the chunk being added so a sum that ends here finishes in this same cycle.
  logic upper_zero;
  always_comb begin
    upper_zero = 1'b1;
    for (int c = 0; c < NUM_CHUNKS; c++) begin
      if ((CIW'(c) > chunk_idx) &&
          ((op_a[c*CHUNK_W +: CHUNK_W] != '0) || (op_b[c*CHUNK_W +: CHUNK_W] != '0)))
        upper_zero = 1'b0;
    end
  end
  assign early_done = ~add_sum[CHUNK_W] & upper_zero;
`else
  assign early_done = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_found) state_d = ADD;
      ADD:     if (chunk_last || early_done) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr    <= '0;
      chunk_idx <= '0;
      carry     <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      res_q     <= '0;
      id_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            op_a      <= sel_a;
            op_b      <= sel_b;
            id_q      <= grant_idx;
            rr_ptr    <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
            carry     <= 1'b0;
            chunk_idx <= '0;
            // Cleared up front so an early finish leaves the unwritten upper chunks at zero.
            res_q     <= '0;
          end
        end
        ADD: begin
          for (int c = 0; c < NUM_CHUNKS; c++) begin
            if (chunk_idx == CIW'(c)) res_q[c*CHUNK_W +: CHUNK_W] <= add_sum[CHUNK_W-1:0];
          end
          carry     <= add_sum[CHUNK_W];
          chunk_idx <= chunk_idx + CIW'(1);
          if (chunk_last) res_q[W] <= add_sum[CHUNK_W];
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE && grant_found && !rst) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign add_a     = (state_q == ADD) ? cur_a : '0;
  assign add_b     = (state_q == ADD) ? cur_b : '0;
  assign add_cin   = (state_q == ADD) & carry;
  assign res_valid = (state_q == DONE);
  assign res_sum   = res_q;
  assign res_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cska_wide_add_sched.sv
// tb/tb_cska_wide_add_sched.sv - randomized scoreboard bench for cska_wide_add_sched
// Honours CSKA_SCHED_EARLY_TERM_EN for expected latencies.
module tb_cska_wide_add_sched;
  localparam int CW = 16, NC = 4, NR = 2, W = CW * NC, IW = 1;

`ifdef CSKA_SCHED_EARLY_TERM_EN
  localparam int T1_LAT = 3, SMALL_LAT = 2;
`else
  localparam int T1_LAT = 5, SMALL_LAT = 5;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req_valid, req_ready;
  logic [NR*W-1:0] req_a, req_b;
  logic [CW-1:0] add_a, add_b;
  logic          add_cin;
  logic [CW:0]   add_sum;
  logic          res_valid, res_ready;
  logic [W:0]    res_sum;
  logic [IW-1:0] res_id;
  logic          busy;

  cska_wide_add_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_id(res_id), .busy(busy)
  );

  // The shared carry-skip slice, as seen from outside: a plain 16-bit add with carry.
  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {{CW{1'b0}}, add_cin};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int id;
    int t;
    int lat;
  } txn_t;
  txn_t q[$];
  int m_rr = 0;
  bit seen = 1'b0;

  function automatic void chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endfunction

  function automatic logic [W-1:0] low_bits(input logic [W-1:0] v, input int k);
    if (k <= 0) return '0;
    if (k >= NC) return v;
    return v & ((W'(1) << (k * CW)) - W'(1));
  endfunction

  // Carry entering chunk k of a+b.
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
    logic [W:0] s;
    s = {1'b0, low_bits(a, k)} + {1'b0, low_bits(b, k)};
    return (s >> (k * CW)) != '0;
  endfunction

  // Cycles from handshake to first res_valid.
  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef CSKA_SCHED_EARLY_TERM_EN
    for (int k = 1; k < NC; k++)
      if (!carry_into(a, b, k) && ((a >> (k * CW)) == '0) && ((b >> (k * CW)) == '0))
        return k + 1;
`endif
    return NC + 1;
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    for (int c = 0; c < NC; c++) begin
      case ($urandom % 4)
        0:       v[c*CW +: CW] = '0;
        1:       v[c*CW +: CW] = '1;
        default: v[c*CW +: CW] = CW'($urandom);
      endcase
    end
    return v;
  endfunction

  always @(negedge clk) begin
    logic [NR-1:0] er;
    logic [W-1:0]  ta, tb2;
    int g, k;
    if (!rst) begin
      if (busy) begin
        chk("ready_while_busy", W'(req_ready), '0);
      end else begin
        er = '0;
        g = -1;
        for (int j = 0; j < NR; j++)
          if (g < 0 && req_valid[(m_rr + j) % NR]) g = (m_rr + j) % NR;
        if (g >= 0) er[g] = 1'b1;
        chk("grant", W'(req_ready), W'(er));
        chk("adder_idle", W'({add_a, add_b, add_cin}), '0);
        if (g >= 0) begin
          q.push_back('{a: req_a[g*W +: W], b: req_b[g*W +: W], id: g, t: cyc,
                        lat: exp_lat(req_a[g*W +: W], req_b[g*W +: W])});
          m_rr = (g + 1) % NR;
        end
      end
      if (q.size() > 0) begin
        k = cyc - q[0].t - 1;
        if (res_valid) begin
          if (!seen) begin
            chk("latency", W'(cyc - q[0].t), W'(q[0].lat));
            seen = 1'b1;
          end
          chk("res_sum", res_sum, {1'b0, q[0].a} + {1'b0, q[0].b});
          chk("res_id", W'(res_id), W'(q[0].id));
          chk("adder_done", W'({add_a, add_b, add_cin}), '0);
          if (res_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end else if (k >= 0) begin
          if (k >= q[0].lat - 1) begin
            chk("res_valid_late", W'(res_valid), 1);
          end else begin
            ta  = q[0].a >> (k * CW);
            tb2 = q[0].b >> (k * CW);
            chk("add_a", W'(add_a), W'(ta[CW-1:0]));
            chk("add_b", W'(add_b), W'(tb2[CW-1:0]));
            chk("add_cin", W'(add_cin), W'(carry_into(q[0].a, q[0].b, k)));
          end
        end
      end else begin
        chk("spurious_res_valid", W'(res_valid), '0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string pre);
    req_valid = '1;
    #1;
    chk({pre, "_req_ready"}, W'(req_ready), '0);
    chk({pre, "_busy"}, W'(busy), '0);
    chk({pre, "_res_valid"}, W'(res_valid), '0);
    chk({pre, "_res_sum"}, res_sum, '0);
    chk({pre, "_res_id"}, W'(res_id), '0);
    chk({pre, "_adder"}, W'({add_a, add_b, add_cin}), '0);
    req_valid = '0;
  endtask

  task automatic flush_model();
    q.delete();
    seen = 1'b0;
    m_rr = 0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy) ok = 1'b1;
    end
    if (!ok) fail_now("drain");
    tick();
  endtask

  task automatic run_one(input string name, input int id, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W:0] lit_sum, input int lit_lat,
                         input int hold, output logic [7:0] cin_hist);
    int t0;
    bit ok;
    cin_hist = '0;
    res_ready = (hold == 0);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_valid[id] = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (req_ready[id]) ok = 1'b1;
    end
    if (!ok) begin
      fail_now({name, "_grant"});
      req_valid[id] = 1'b0;
      return;
    end
    t0 = cyc;
    tick();
    req_valid[id] = 1'b0;
    req_a[id*W +: W] = rand_op();
    req_b[id*W +: W] = rand_op();
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (res_valid) ok = 1'b1;
      else if (n < 8) cin_hist[n] = add_cin;
    end
    if (!ok) begin
      fail_now({name, "_result"});
      res_ready = 1'b1;
      return;
    end
    chk({name, "_lat"}, W'(cyc - t0), W'(lit_lat));
    chk({name, "_sum"}, res_sum, lit_sum);
    chk({name, "_id"}, W'(res_id), W'(id));
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      res_ready = 1'b1;
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]    h;
    logic [NR-1:0] hs;
    int grants[6], ids[6];
    int ng, nr;
    bit ok;

    req_valid = '0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    tick();

    run_one("t1", 0, 64'h1_FFFF, 64'h1, 65'h2_0000, T1_LAT, 0, h);
    run_one("ripple", 0, '1, 64'h1, 65'h1_0000_0000_0000_0000, 5, 0, h);
    chk("ripple_cin", W'(h[3:0]), W'(4'b1110));
    run_one("small", 1, 64'h1234, 64'h1, 65'h1235, SMALL_LAT, 0, h);
    run_one("zero", 1, '0, '0, '0, SMALL_LAT, 0, h);

    rst = 1'b1;
    flush_model();
    check_reset("reset2");
    tick();
    rst = 1'b0;
    tick();

    for (int k = 0; k < 6; k++) begin
      grants[k] = -1;
      ids[k] = -1;
    end
    req_a = {rand_op(), rand_op()};
    req_b = {rand_op(), rand_op()};
    req_valid = '1;
    res_ready = 1'b1;
    ng = 0;
    nr = 0;
    for (int c = 0; c < 200 && nr < 6; c++) begin
      @(negedge clk);
      hs = req_ready;
      if (hs != '0 && ng < 6) begin
        grants[ng] = hs[1] ? 1 : 0;
        ng++;
      end
      if (res_valid && res_ready) begin
        ids[nr] = int'(res_id);
        nr++;
      end
      tick();
      if (hs != '0) begin
        req_a = {rand_op(), rand_op()};
        req_b = {rand_op(), rand_op()};
      end
    end
    req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      chk("rr_grant", W'(grants[k]), W'(k % 2));
      chk("rr_id", W'(ids[k]), W'(k % 2));
    end
    drain();

    req_a[W +: W] = rand_op();
    req_b[W +: W] = rand_op();
    req_valid[1] = 1'b1;
    run_one("bp", 0, 64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000,
            65'h1_0000_0001_0000_0000, 5, 10, h);
    @(negedge clk);
    chk("bp_next_grant", W'(req_ready), W'(2'b10));
    tick();
    drain();

    req_a[0 +: W] = rand_op();
    req_b[0 +: W] = rand_op();
    req_valid[0] = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (req_ready[0]) ok = 1'b1;
    end
    if (!ok) fail_now("midrst_grant");
    tick();
    req_valid = '0;
    tick();
    tick();
    rst = 1'b1;
    flush_model();
    check_reset("midrst");
    @(negedge clk);
    chk("midrst_hold_valid", W'({res_valid, busy}), '0);
    tick();
    rst = 1'b0;
    req_a = {rand_op(), rand_op()};
    req_b = {rand_op(), rand_op()};
    req_valid = '1;
    @(negedge clk);
    chk("post_reset_tie", W'(req_ready), W'(2'b01));
    tick();
    req_valid = '0;
    drain();

    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      hs = req_ready & req_valid;
      tick();
      for (int i = 0; i < NR; i++) begin
        if (hs[i] || !req_valid[i]) begin
          req_valid[i] = hs[i] ? ($urandom % 2 == 0) : ($urandom % 4 == 0);
          req_a[i*W +: W] = rand_op();
          req_b[i*W +: W] = rand_op();
        end else if ($urandom % 16 == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      res_ready = ($urandom % 4) != 0;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
